// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the runtime-loadable instruction memory.
package instr_mem_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StDone = 2'd2
    } ld_state_e;

    localparam logic [15:0] FillDefault = 16'hFFFF;

endpackage

// File: rtl/instr_mem_array.sv
// DEPTH x DATA_W storage: one synchronous write port, one synchronous read port.
// Contents power up filled with FILL.
module instr_mem_array #(
    parameter int unsigned         DATA_W    = 16,
    parameter int unsigned         ADDR_W    = 8,
    parameter int unsigned         DEPTH     = 256,
    parameter logic [DATA_W-1:0]   FILL      = '1,
    parameter string               INIT_FILE = ""
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int unsigned       IdxW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IdxW:0]     DepthI = DEPTH[IdxW:0];

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Power-up image; reset never touches the array.
    initial begin
        for (logic [IdxW:0] i = '0; i < DepthI; i++) begin
            mem_q[i[IdxW-1:0]] = FILL;
        end
    end

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i[IdxW-1:0]] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i[IdxW-1:0]];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_mem_prog.sv
// Runtime-loadable instruction memory: sync fetch port plus a valid/ready load port.
// Define INSTR_MEM_OUTREG_EN to add a second output register stage (read latency 2).
module instr_mem_prog
    import instr_mem_pkg::*;
#(
    parameter int unsigned         DATA_W    = 16,
    parameter int unsigned         ADDR_W    = 8,
    parameter int unsigned         DEPTH     = 256,
    parameter logic [DATA_W-1:0]   FILL      = FillDefault,
    parameter string               INIT_FILE = ""
) (
    input  logic              I_CLK,
    input  logic              I_RST,
    input  logic              I_EN,
    input  logic [ADDR_W-1:0] I_ADDR,
    output logic [DATA_W-1:0] O_INSTR,
    output logic              O_VALID,
    input  logic              I_LD_START,
    input  logic [ADDR_W-1:0] I_LD_BASE,
    input  logic [ADDR_W:0]   I_LD_COUNT,
    input  logic              I_LD_VALID,
    input  logic [DATA_W-1:0] I_LD_DATA,
    output logic              O_LD_READY,
    output logic              O_LD_BUSY,
    output logic              O_LD_DONE
);

    localparam logic [ADDR_W:0]   DepthW   = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   CntOne   = (ADDR_W + 1)'(1);

    ld_state_e         state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W:0]   cnt_q;
    logic              ready_q, busy_q, done_q;

    logic [ADDR_W-1:0] ptr_inc;
    logic              ptr_ok, wr_en;
    logic              blk, oor, rd_req, rd_en;
    logic              valid1_q, valid1_d, fill1_q, fill1_d;
    logic [DATA_W-1:0] rdata, instr1;

    always_comb begin
        ptr_inc = (ptr_q == LastAddr) ? '0 : ptr_q + 1'b1;
        ptr_ok  = {1'b0, ptr_q} < DepthW;
        // Out-of-range beats still advance ptr/cnt, they just never reach the array.
        wr_en   = (state_q == StLoad) && I_LD_VALID && ptr_ok;
    end

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (I_LD_START) begin
                        ptr_q  <= I_LD_BASE;
                        cnt_q  <= I_LD_COUNT;
                        busy_q <= 1'b1;
                        if (I_LD_COUNT != '0) begin
                            state_q <= StLoad;
                            ready_q <= 1'b1;
                        end else begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end
                    end
                end
                StLoad: begin
                    if (I_LD_VALID) begin
                        ptr_q <= ptr_inc;
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == CntOne) begin
                            state_q <= StDone;
                            ready_q <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // A start accepted this edge blocks fetch too, so outputs read FILL for every busy cycle.
    always_comb begin
        blk      = busy_q || ((state_q == StIdle) && I_LD_START);
        oor      = {1'b0, I_ADDR} >= DepthW;
        rd_req   = I_EN && !blk;
        rd_en    = rd_req && !oor;
        valid1_d = rd_req;
        fill1_d  = fill1_q;
        if (blk) begin
            fill1_d = 1'b1;
        end else if (I_EN) begin
            fill1_d = oor;
        end
    end

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            valid1_q <= 1'b0;
            fill1_q  <= 1'b1;
        end else begin
            valid1_q <= valid1_d;
            fill1_q  <= fill1_d;
        end
    end

    instr_mem_array #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .FILL     (FILL),
        .INIT_FILE(INIT_FILE)
    ) u_array (
        .clk_i  (I_CLK),
        .we_i   (wr_en),
        .waddr_i(ptr_q),
        .wdata_i(I_LD_DATA),
        .re_i   (rd_en),
        .raddr_i(I_ADDR),
        .rdata_o(rdata)
    );

    assign instr1 = fill1_q ? FILL : rdata;

`ifdef INSTR_MEM_OUTREG_EN
    logic [DATA_W-1:0] instr2_q;
    logic              valid2_q;

    always_ff @(posedge I_CLK) begin
        if (I_RST || blk) begin
            instr2_q <= FILL;
            valid2_q <= 1'b0;
        end else begin
            instr2_q <= instr1;
            valid2_q <= valid1_q;
        end
    end

    assign O_INSTR = instr2_q;
    assign O_VALID = valid2_q;
`else
    assign O_INSTR = instr1;
    assign O_VALID = valid1_q;
`endif

    assign O_LD_READY = ready_q;
    assign O_LD_BUSY  = busy_q;
    assign O_LD_DONE  = done_q;

endmodule

// File: tb/tb_instr_mem_prog.sv
// Directed bench: a DEPTH=256 and a DEPTH=200 instance driven by the same stimulus.
module tb_instr_mem_prog;

`ifdef INSTR_MEM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst, en, ld_start, ld_valid;
    logic [7:0]  addr, ld_base;
    logic [8:0]  ld_count;
    logic [15:0] ld_data;

    logic [15:0] instr_a, instr_b;
    logic        valid_a, ready_a, busy_a, done_a;
    logic        valid_b, ready_b, busy_b, done_b;

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk = ~clk;

    instr_mem_prog dut_a (
        .I_CLK(clk), .I_RST(rst), .I_EN(en), .I_ADDR(addr),
        .O_INSTR(instr_a), .O_VALID(valid_a),
        .I_LD_START(ld_start), .I_LD_BASE(ld_base), .I_LD_COUNT(ld_count),
        .I_LD_VALID(ld_valid), .I_LD_DATA(ld_data),
        .O_LD_READY(ready_a), .O_LD_BUSY(busy_a), .O_LD_DONE(done_a)
    );

    instr_mem_prog #(.DEPTH(200)) dut_b (
        .I_CLK(clk), .I_RST(rst), .I_EN(en), .I_ADDR(addr),
        .O_INSTR(instr_b), .O_VALID(valid_b),
        .I_LD_START(ld_start), .I_LD_BASE(ld_base), .I_LD_COUNT(ld_count),
        .I_LD_VALID(ld_valid), .I_LD_DATA(ld_data),
        .O_LD_READY(ready_b), .O_LD_BUSY(busy_b), .O_LD_DONE(done_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [15:0] exp,
                      input bit use_b);
        en   = 1'b1;
        addr = a;
        tick();
        en = 1'b0;
        repeat (LAT - 1) tick();
        if (use_b) begin
            chk({tag, "_data"}, {16'h0, instr_b}, {16'h0, exp});
            chk({tag, "_valid"}, {31'h0, valid_b}, 32'd1);
        end else begin
            chk({tag, "_data"}, {16'h0, instr_a}, {16'h0, exp});
            chk({tag, "_valid"}, {31'h0, valid_a}, 32'd1);
        end
    endtask

    task automatic beat(input logic [15:0] d);
        ld_valid = 1'b1;
        ld_data  = d;
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic start(input logic [7:0] base, input logic [8:0] count);
        ld_start = 1'b1;
        ld_base  = base;
        ld_count = count;
        tick();
        ld_start = 1'b0;
    endtask

    initial begin
        logic [15:0] exp_s [3];
        exp_s[0] = 16'hA1A1;
        exp_s[1] = 16'hB2B2;
        exp_s[2] = 16'hC3C3;

        rst = 1'b1; en = 1'b0; addr = '0; ld_start = 1'b0; ld_base = '0;
        ld_count = '0; ld_valid = 1'b0; ld_data = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_instr", {16'h0, instr_a}, 32'hFFFF);
        chk("rst_valid", {31'h0, valid_a}, 32'd0);
        chk("rst_ready", {31'h0, ready_a}, 32'd0);
        chk("rst_busy", {31'h0, busy_a}, 32'd0);
        chk("rst_done", {31'h0, done_a}, 32'd0);

        // No INIT_FILE: every word powers up as FILL.
        for (int i = 0; i < 4; i++) rd("init_rd", 8'(i), 16'hFFFF, 1'b0);
        tick();
        chk("idle_valid", {31'h0, valid_a}, 32'd0);

        // Load three words with a two-cycle gap; fetch attempted during the gap.
        start(8'h10, 9'd3);
        chk("ld_busy", {31'h0, busy_a}, 32'd1);
        chk("ld_ready", {31'h0, ready_a}, 32'd1);
        beat(16'hA1A1);
        en = 1'b1; addr = 8'h00;
        tick();
        chk("gap1_ready", {31'h0, ready_a}, 32'd1);
        chk("blk_valid", {31'h0, valid_a}, 32'd0);
        chk("blk_instr", {16'h0, instr_a}, 32'hFFFF);
        tick();
        en = 1'b0;
        chk("gap2_ready", {31'h0, ready_a}, 32'd1);
        chk("gap2_done", {31'h0, done_a}, 32'd0);
        beat(16'hB2B2);
        beat(16'hC3C3);
        chk("done_pulse", {31'h0, done_a}, 32'd1);
        chk("done_ready", {31'h0, ready_a}, 32'd0);
        chk("done_busy", {31'h0, busy_a}, 32'd1);
        tick();
        chk("after_done", {31'h0, done_a}, 32'd0);
        chk("after_busy", {31'h0, busy_a}, 32'd0);

        // Back-to-back reads stream one word per cycle.
        for (int k = 0; k < 3 + LAT - 1; k++) begin
            addr = 8'h10 + 8'(k);
            en   = (k < 3);
            tick();
            if (k >= LAT - 1) begin
                chk("stream_data", {16'h0, instr_a}, {16'h0, exp_s[k-LAT+1]});
                chk("stream_valid", {31'h0, valid_a}, 32'd1);
            end
        end
        en = 1'b0;
        tick();

        // Zero-length load: one busy cycle with DONE, memory untouched.
        start(8'h10, 9'd0);
        chk("z_busy", {31'h0, busy_a}, 32'd1);
        chk("z_done", {31'h0, done_a}, 32'd1);
        chk("z_ready", {31'h0, ready_a}, 32'd0);
        tick();
        chk("z_busy_off", {31'h0, busy_a}, 32'd0);
        chk("z_done_off", {31'h0, done_a}, 32'd0);
        rd("z_mem", 8'h10, 16'hA1A1, 1'b0);

        // Pointer wrap on the DEPTH=200 instance.
        start(8'd199, 9'd2);
        beat(16'h1111);
        beat(16'h2222);
        chk("wrap_done_b", {31'h0, done_b}, 32'd1);
        tick();
        chk("wrap_busy_b", {31'h0, busy_b}, 32'd0);
        chk("wrap_ready_b", {31'h0, ready_b}, 32'd0);
        rd("wrap_199", 8'd199, 16'h1111, 1'b1);
        rd("wrap_0", 8'd0, 16'h2222, 1'b1);
        rd("oor_250", 8'd250, 16'hFFFF, 1'b1);
        rd("nowrap_200", 8'd200, 16'h2222, 1'b0);
        rd("nowrap_0", 8'd0, 16'hFFFF, 1'b0);

        // Reset after the first of four beats.
        start(8'h20, 9'd4);
        beat(16'h5A5A);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_ready", {31'h0, ready_a}, 32'd0);
        chk("mid_busy", {31'h0, busy_a}, 32'd0);
        chk("mid_instr", {16'h0, instr_a}, 32'hFFFF);
        ld_valid = 1'b1; ld_data = 16'hDEAD;
        tick();
        ld_valid = 1'b0;
        chk("mid_idle_busy", {31'h0, busy_a}, 32'd0);
        rd("mid_kept", 8'h20, 16'h5A5A, 1'b0);
        rd("mid_next", 8'h21, 16'hFFFF, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
